regs_mp: RTL and testbench
==========================

REGS_MP -- requirements
Module: regs_mp

Interface
REQ-001 Parameter DATA_W, default 64, register width in bits.
REQ-002 Parameter ADDR_W, default 5, address width; depth = 2^ADDR_W entries, entry 0 hard-wired zero.
REQ-003 clk_i  input  1  sole clock; all state updates on posedge.
REQ-004 rst_i  input  1  reset; synchronous, active-high.
REQ-005 reg_raddr1_i  input  ADDR_W  read port 1 address.
REQ-006 reg_raddr2_i  input  ADDR_W  read port 2 address.
REQ-007 reg_rdata1_o  output  DATA_W  read port 1 data, combinational.
REQ-008 reg_rdata2_o  output  DATA_W  read port 2 data, combinational.
REQ-009 reg_wen0_i / reg_waddr0_i / reg_wdata0_i  input  1/ADDR_W/DATA_W  write port 0.
REQ-010 reg_wen1_i / reg_waddr1_i / reg_wdata1_i  input  1/ADDR_W/DATA_W  write port 1, higher priority.
REQ-011 ready_o  output  1  high when the initialisation sweep is complete and writes are accepted.

Function
REQ-012 The block SHALL have two states: CLEAR and IDLE.
REQ-013 In CLEAR, each cycle with rst_i low SHALL write zero to entry clr_ptr and increment clr_ptr (ADDR_W bits).
REQ-014 On the cycle clr_ptr equals 2^ADDR_W-1, the block SHALL clear that entry and transition to IDLE; CLEAR lasts exactly 2^ADDR_W-1 cycles after rst_i falls.
REQ-015 ready_o SHALL be 1 only in IDLE.
REQ-016 In CLEAR, both write ports SHALL be ignored, and both read ports SHALL return zero.
REQ-017 In IDLE, a port with wen high and nonzero waddr SHALL write wdata to that entry at the posedge.
REQ-018 Writes to address 0 SHALL be discarded; reads of address 0 SHALL return zero in all states.
REQ-019 If both write ports are enabled to the same nonzero address, port 1 data SHALL be stored and port 0 discarded.
REQ-020 Writes to different addresses in the same cycle SHALL both be stored.
REQ-021 Read data SHALL reflect stored contents with zero-cycle latency (subject to REQ-027).

Reset
REQ-022 While rst_i is high at a posedge, the block SHALL enter CLEAR with clr_ptr=1, and ready_o SHALL be 0 from the following cycle.
REQ-023 rst_i asserted mid-sweep or in IDLE SHALL restart the sweep from clr_ptr=1.
REQ-024 Reset SHALL take priority over any write in the same cycle.
REQ-025 Contents are undefined until the sweep completes; readers SHALL gate on ready_o.

Configuration
REQ-026 Macro REGS_MP_BYPASS_EN selects write-to-read forwarding.
REQ-027 With REGS_MP_BYPASS_EN defined, in IDLE a read whose address matches an enabled, nonzero write address in the same cycle SHALL return that write data (port 1 over port 0 on a double match).
REQ-028 Without REGS_MP_BYPASS_EN, reads SHALL return the pre-write stored value; new data SHALL be visible the cycle after the write.

Verification
REQ-029 rst_i high 1 cycle, then low -> ready_o=0 for 31 cycles, ready_o=1 on cycle 32 (ADDR_W=5); every read returns 0.
REQ-030 IDLE: wen0=1, waddr0=3, wdata0=0xA5; next cycle raddr1=3 -> rdata1=0xA5; wen1=1, waddr1=0, wdata1=0xFF; raddr2=0 -> rdata2=0.
REQ-031 wen0=wen1=1, both addr 7, wdata0=0x11, wdata1=0x22 -> entry 7 reads 0x22 next cycle.
REQ-032 Entry 5=0x1; same cycle wen0=1, waddr0=5, wdata0=0x2, raddr1=5 -> rdata1=0x2 with bypass, 0x1 without; 0x2 on the following cycle in both builds.
REQ-033 rst_i pulsed at sweep cycle 10 -> sweep restarts; ready_o stays 0 for 31 further cycles; a write during the sweep is not stored.
REQ-034 Entry 9=0xDEAD in IDLE, rst_i pulsed -> after ready_o rises, entry 9 reads 0.

Source files
------------

// File: rtl/regs_mp.sv
// Two-write/two-read register file with entry 0 hard-wired to zero and a post-reset clearing sweep.
// Define REGS_MP_BYPASS_EN to forward same-cycle write data to matching reads.
module regs_mp #(
   parameter int DATA_W = 64,
   parameter int ADDR_W = 5
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [ADDR_W-1:0] reg_raddr1_i,
   input  logic [ADDR_W-1:0] reg_raddr2_i,
   output logic [DATA_W-1:0] reg_rdata1_o,
   output logic [DATA_W-1:0] reg_rdata2_o,
   input  logic              reg_wen0_i,
   input  logic [ADDR_W-1:0] reg_waddr0_i,
   input  logic [DATA_W-1:0] reg_wdata0_i,
   input  logic              reg_wen1_i,
   input  logic [ADDR_W-1:0] reg_waddr1_i,
   input  logic [DATA_W-1:0] reg_wdata1_i,
   output logic              ready_o
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] LAST = '1;

   typedef enum logic {CLEAR, IDLE} state_t;

   state_t            state, state_next;
   logic [ADDR_W-1:0] clr_ptr, clr_ptr_next;
   logic              we0, we1;
   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state   <= CLEAR;
         clr_ptr <= ADDR_W'(1);
      end else begin
         state   <= state_next;
         clr_ptr <= clr_ptr_next;
      end
   end

   // Port 1 wins a same-address collision, so port 0 is masked off in that case.
   always_comb begin
      state_next   = state;
      clr_ptr_next = clr_ptr;
      we0          = 1'b0;
      we1          = 1'b0;
      case (state)
         CLEAR: begin
            clr_ptr_next = clr_ptr + ADDR_W'(1);
            if (clr_ptr == LAST) state_next = IDLE;
         end
         IDLE: begin
            we1 = reg_wen1_i && (reg_waddr1_i != '0);
            we0 = reg_wen0_i && (reg_waddr0_i != '0) &&
                  !(we1 && (reg_waddr1_i == reg_waddr0_i));
         end
         default: state_next = CLEAR;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         if (state == CLEAR) mem[clr_ptr] <= '0;
         if (we0) mem[reg_waddr0_i] <= reg_wdata0_i;
         if (we1) mem[reg_waddr1_i] <= reg_wdata1_i;
      end
   end

   function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
      logic [DATA_W-1:0] data;
      data = '0;
      if (state == IDLE && addr != '0) begin
         data = mem[addr];
`ifdef REGS_MP_BYPASS_EN
         if (reg_wen0_i && reg_waddr0_i == addr) data = reg_wdata0_i;
         if (reg_wen1_i && reg_waddr1_i == addr) data = reg_wdata1_i;
`endif
      end
      return data;
   endfunction

   always_comb begin
      reg_rdata1_o = read_port(reg_raddr1_i);
      reg_rdata2_o = read_port(reg_raddr2_i);
   end

   assign ready_o = (state == IDLE);

endmodule

// File: tb/tb_regs_mp.sv
// Self-checking bench for regs_mp: directed scenarios plus randomized traffic against a behavioural model.
module tb_regs_mp;

   localparam int DATA_W = 64;
   localparam int ADDR_W = 5;
   localparam int DEPTH  = 1 << ADDR_W;

   logic              clk = 1'b0;
   logic              rst;
   logic [ADDR_W-1:0] raddr1, raddr2, waddr0, waddr1;
   logic [DATA_W-1:0] rdata1, rdata2, wdata0, wdata1;
   logic              wen0, wen1, ready;

   int n_tests = 0;
   int n_fail  = 0;

   // Behavioural model: a plain array, a ready flag and a count of low-reset cycles since reset.
   logic [DATA_W-1:0] ref_mem [DEPTH];
   bit                ref_ready;
   int                ref_cnt;

   always #5 clk = ~clk;

   regs_mp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .reg_raddr1_i (raddr1),
      .reg_raddr2_i (raddr2),
      .reg_rdata1_o (rdata1),
      .reg_rdata2_o (rdata2),
      .reg_wen0_i   (wen0),
      .reg_waddr0_i (waddr0),
      .reg_wdata0_i (wdata0),
      .reg_wen1_i   (wen1),
      .reg_waddr1_i (waddr1),
      .reg_wdata1_i (wdata1),
      .ready_o      (ready)
   );

   function automatic logic [DATA_W-1:0] ref_read(input logic [ADDR_W-1:0] a);
      if (!ref_ready || a == 0) return '0;
`ifdef REGS_MP_BYPASS_EN
      if (wen1 && waddr1 == a) return wdata1;
      if (wen0 && waddr0 == a) return wdata0;
`endif
      return ref_mem[a];
   endfunction

   // Advance one clock, apply the held inputs to the model, then step off the edge.
   task automatic tick();
      @(posedge clk);
      if (rst) begin
         ref_ready = 0;
         ref_cnt   = 0;
         for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
      end else if (!ref_ready) begin
         ref_cnt++;
         if (ref_cnt == DEPTH - 1) ref_ready = 1;
      end else begin
         if (wen0 && waddr0 != 0) ref_mem[waddr0] = wdata0;
         if (wen1 && waddr1 != 0) ref_mem[waddr1] = wdata1;
      end
      #1;
   endtask

   task automatic idle_inputs();
      rst = 0; wen0 = 0; wen1 = 0;
      waddr0 = '0; waddr1 = '0; wdata0 = '0; wdata1 = '0;
      raddr1 = '0; raddr2 = '0;
   endtask

   task automatic random_writes();
      wen0   = 1'($urandom_range(0, 1));
      wen1   = 1'($urandom_range(0, 1));
      waddr0 = ADDR_W'($urandom_range(0, DEPTH - 1));
      waddr1 = ADDR_W'($urandom_range(0, DEPTH - 1));
      wdata0 = {$urandom, $urandom};
      wdata1 = {$urandom, $urandom};
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1;
      tick();
      rst = 0;
      for (int i = 0; i < DEPTH - 1; i++) begin
         random_writes();
         raddr1 = ADDR_W'($urandom_range(0, DEPTH - 1));
         raddr2 = ADDR_W'($urandom_range(0, DEPTH - 1));
         #1;
         n_tests++;
         if (ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready_low cycle %0d: got %b want 0", i, ready);
         end
         n_tests++;
         if (rdata1 !== '0 || rdata2 !== '0) begin
            n_fail++;
            $display("FAIL reset_read_zero cycle %0d: got %h/%h want 0", i, rdata1, rdata2);
         end
         tick();
      end
      idle_inputs();
      #1;
      n_tests++;
      if (ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_ready_high: got %b want 1", ready);
      end
      for (int a = 0; a < DEPTH; a++) begin
         raddr1 = ADDR_W'(a);
         raddr2 = ADDR_W'(DEPTH - 1 - a);
         #1;
         n_tests++;
         if (rdata1 !== '0 || rdata2 !== '0) begin
            n_fail++;
            $display("FAIL swept_zero addr %0d: got %h/%h want 0", a, rdata1, rdata2);
         end
      end
   endtask

   task automatic test_basic();
      idle_inputs();
      wen0 = 1; waddr0 = 5'd3; wdata0 = 64'hA5;
      tick();
      idle_inputs();
      raddr1 = 5'd3;
      wen1 = 1; waddr1 = 5'd0; wdata1 = 64'hFF;
      raddr2 = 5'd0;
      #1;
      n_tests++;
      if (rdata1 !== 64'hA5) begin
         n_fail++;
         $display("FAIL basic_read3: got %h want a5", rdata1);
      end
      n_tests++;
      if (rdata2 !== '0) begin
         n_fail++;
         $display("FAIL basic_addr0_same_cycle: got %h want 0", rdata2);
      end
      tick();
      idle_inputs();
      #1;
      n_tests++;
      if (rdata2 !== '0) begin
         n_fail++;
         $display("FAIL basic_addr0_after: got %h want 0", rdata2);
      end
   endtask

   task automatic test_collision();
      idle_inputs();
      wen0 = 1; waddr0 = 5'd7; wdata0 = 64'h11;
      wen1 = 1; waddr1 = 5'd7; wdata1 = 64'h22;
      tick();
      idle_inputs();
      raddr1 = 5'd7;
      #1;
      n_tests++;
      if (rdata1 !== 64'h22) begin
         n_fail++;
         $display("FAIL collision_port1_wins: got %h want 22", rdata1);
      end
      // Distinct addresses in one cycle must both land.
      wen0 = 1; waddr0 = 5'd10; wdata0 = 64'h1010;
      wen1 = 1; waddr1 = 5'd11; wdata1 = 64'h1111;
      tick();
      idle_inputs();
      raddr1 = 5'd10; raddr2 = 5'd11;
      #1;
      n_tests++;
      if (rdata1 !== 64'h1010 || rdata2 !== 64'h1111) begin
         n_fail++;
         $display("FAIL dual_write: got %h/%h want 1010/1111", rdata1, rdata2);
      end
   endtask

   task automatic test_bypass();
      logic [DATA_W-1:0] exp_now;
`ifdef REGS_MP_BYPASS_EN
      exp_now = 64'h2;
`else
      exp_now = 64'h1;
`endif
      idle_inputs();
      wen0 = 1; waddr0 = 5'd5; wdata0 = 64'h1;
      tick();
      idle_inputs();
      wen0 = 1; waddr0 = 5'd5; wdata0 = 64'h2; raddr1 = 5'd5;
      #1;
      n_tests++;
      if (rdata1 !== exp_now) begin
         n_fail++;
         $display("FAIL bypass_same_cycle: got %h want %h", rdata1, exp_now);
      end
      tick();
      idle_inputs();
      raddr1 = 5'd5;
      #1;
      n_tests++;
      if (rdata1 !== 64'h2) begin
         n_fail++;
         $display("FAIL bypass_next_cycle: got %h want 2", rdata1);
      end
   endtask

   task automatic test_mid_reset();
      idle_inputs();
      wen0 = 1; waddr0 = 5'd3; wdata0 = 64'hBEEF;
      tick();
      idle_inputs();
      rst = 1;
      tick();
      rst = 0;
      for (int i = 0; i < 10; i++) tick();
      rst = 1;
      tick();
      rst = 0;
      for (int i = 0; i < DEPTH - 1; i++) begin
         if (i == 20) begin
            wen0 = 1; waddr0 = 5'd3; wdata0 = 64'h1234;
         end else begin
            wen0 = 0;
         end
         #1;
         n_tests++;
         if (ready !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_ready_low cycle %0d: got %b want 0", i, ready);
         end
         tick();
      end
      idle_inputs();
      raddr1 = 5'd3;
      #1;
      n_tests++;
      if (ready !== 1'b1 || rdata1 !== '0) begin
         n_fail++;
         $display("FAIL mid_reset_done: got ready=%b data=%h want ready=1 data=0", ready, rdata1);
      end
   endtask

   task automatic test_reset_clears();
      idle_inputs();
      wen1 = 1; waddr1 = 5'd9; wdata1 = 64'hDEAD;
      tick();
      idle_inputs();
      raddr2 = 5'd9;
      #1;
      n_tests++;
      if (rdata2 !== 64'hDEAD) begin
         n_fail++;
         $display("FAIL clears_before: got %h want dead", rdata2);
      end
      rst = 1;
      tick();
      rst = 0;
      for (int i = 0; i < DEPTH - 1; i++) tick();
      #1;
      n_tests++;
      if (ready !== 1'b1 || rdata2 !== '0) begin
         n_fail++;
         $display("FAIL clears_after: got ready=%b data=%h want ready=1 data=0", ready, rdata2);
      end
   endtask

   task automatic test_random();
      logic [DATA_W-1:0] exp1, exp2;
      for (int c = 0; c < 600; c++) begin
         random_writes();
         // Skew toward address collisions with the read ports.
         raddr1 = ($urandom_range(0, 2) == 0) ? waddr0 : ADDR_W'($urandom_range(0, DEPTH - 1));
         raddr2 = ($urandom_range(0, 2) == 0) ? waddr1 : ADDR_W'($urandom_range(0, DEPTH - 1));
         rst    = ($urandom_range(0, 149) == 0);
         #1;
         exp1 = ref_read(raddr1);
         exp2 = ref_read(raddr2);
         n_tests++;
         if (ready !== ref_ready || rdata1 !== exp1 || rdata2 !== exp2) begin
            n_fail++;
            $display("FAIL random cycle %0d: got ready=%b r1=%h r2=%h want ready=%b r1=%h r2=%h",
                     c, ready, rdata1, rdata2, ref_ready, exp1, exp2);
         end
         tick();
      end
   endtask

   initial begin
      idle_inputs();
      ref_ready = 0;
      ref_cnt   = 0;
      #1;
      test_reset();
      test_basic();
      test_collision();
      test_bypass();
      test_mid_reset();
      test_reset_clears();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
